// File: rtl/pipe_reg_slice_if.sv
// rtl/pipe_reg_slice_if.sv - upstream/downstream handshake bundle for pipe_reg_slice
interface pipe_reg_slice_if #(
  parameter int DATA_W = 81,
  parameter int DEPTH  = 1
);
  localparam int OCC_W = $clog2(2 * DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;

  // side that feeds payloads in and drains them out
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // the register slice itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_reg_slice.sv
// rtl/pipe_reg_slice.sv - DEPTH-stage valid/ready register slice with flush and bubble NOPs
// Optional feature macro: PIPE_SKID_EN (adds one skid entry per stage, registered in_ready).
module pipe_reg_slice #(
  parameter int                DATA_W    = 81,
  parameter int                DEPTH     = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  pipe_reg_slice_if.slave bus
);
  localparam int OCC_W = $clog2(2 * DEPTH + 1);

  logic             accept;
  logic             take;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

`ifdef PIPE_SKID_EN
  // Each stage is a main register plus a skid register; a stage's ready is
  // registered from its own skid occupancy so out_ready never reaches in_ready.
  logic [DEPTH-1:0]  mv_q, mv_d, sv_q, sv_d, rdy_q, rdy_d, dn_rdy, src_v;
  logic [DATA_W-1:0] md_q [DEPTH];
  logic [DATA_W-1:0] md_d [DEPTH];
  logic [DATA_W-1:0] sd_q [DEPTH];
  logic [DATA_W-1:0] sd_d [DEPTH];
  logic [DATA_W-1:0] src_d [DEPTH];

  assign bus.in_ready  = rdy_q[0] & ~flush;
  assign bus.out_valid = mv_q[DEPTH-1];
  assign bus.out_data  = md_q[DEPTH-1];
  assign accept        = bus.in_valid & bus.in_ready;
  assign take          = mv_q[DEPTH-1] & bus.out_ready;

  // per-stage skid buffer next state: drain skid into main first, else load from upstream
  always_comb begin
    logic acc;
    acc      = 1'b0;
    src_v[0] = accept;
    src_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = mv_q[i-1];
      src_d[i] = md_q[i-1];
    end
    dn_rdy[DEPTH-1] = bus.out_ready;
    for (int i = 0; i < DEPTH - 1; i++) begin
      dn_rdy[i] = rdy_q[i+1];
    end
    mv_d = mv_q;
    sv_d = sv_q;
    for (int i = 0; i < DEPTH; i++) begin
      md_d[i] = md_q[i];
      sd_d[i] = sd_q[i];
      acc     = src_v[i] & rdy_q[i];
      if (!mv_q[i] || dn_rdy[i]) begin
        if (sv_q[i]) begin
          mv_d[i] = 1'b1;
          md_d[i] = sd_q[i];
          sv_d[i] = 1'b0;
          sd_d[i] = NOP_VALUE;
        end else if (acc) begin
          mv_d[i] = 1'b1;
          md_d[i] = src_d[i];
        end else begin
          mv_d[i] = 1'b0;
          md_d[i] = NOP_VALUE;
        end
      end else if (acc) begin
        sv_d[i] = 1'b1;
        sd_d[i] = src_d[i];
      end
    end
    rdy_d = ~sv_d;
  end

  // stage registers; ready stays low through reset and rises on the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_q  <= '0;
      sv_q  <= '0;
      rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        md_q[i] <= NOP_VALUE;
        sd_q[i] <= NOP_VALUE;
      end
    end else if (flush) begin
      mv_q  <= '0;
      sv_q  <= '0;
      rdy_q <= '1;
      for (int i = 0; i < DEPTH; i++) begin
        md_q[i] <= NOP_VALUE;
        sd_q[i] <= NOP_VALUE;
      end
    end else begin
      mv_q  <= mv_d;
      sv_q  <= sv_d;
      rdy_q <= rdy_d;
      for (int i = 0; i < DEPTH; i++) begin
        md_q[i] <= md_d[i];
        sd_q[i] <= sd_d[i];
      end
    end
  end
`else
  // One entry per stage; a stage can load whenever some stage at or below it
  // is empty or the sink is taking, so the enable is a closed form per stage.
  logic [DEPTH-1:0]  v_q, v_d, en, src_v;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [DATA_W-1:0] src_d [DEPTH];

  assign bus.in_ready  = en[0] & ~flush & ~rst;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign accept        = bus.in_valid & bus.in_ready;
  assign take          = v_q[DEPTH-1] & bus.out_ready;

  // stage load enables from the downstream fullness chain
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    en       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & v_q[i];
      en[i]    = bus.out_ready | ~all_full;
    end
  end

  // stage next state: load predecessor on enable, a missing predecessor becomes a NOP bubble
  always_comb begin
    src_v[0] = accept;
    src_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
    end
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
      if (en[i]) begin
        v_d[i] = src_v[i];
        d_d[i] = src_v[i] ? src_d[i] : NOP_VALUE;
      end
    end
  end

  // stage registers with async reset and synchronous flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= NOP_VALUE;
    end else if (flush) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= NOP_VALUE;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end
`endif

  assign bus.occupancy = occ_q;

  // entry count: up on accept only, down on take only, unchanged when both
  always_comb begin
    occ_d = occ_q;
    if (accept && !take) occ_d = occ_q + OCC_W'(1);
    else if (take && !accept) occ_d = occ_q - OCC_W'(1);
  end

  // entry counter register, cleared by reset or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else if (flush) occ_q <= '0;
    else occ_q <= occ_d;
  end
endmodule

// File: tb/tb_pipe_reg_slice.sv
// tb/tb_pipe_reg_slice.sv - directed and scoreboard checks for pipe_reg_slice (DEPTH=2)
module tb_pipe_reg_slice;
  localparam int DATA_W = 81;
  localparam int DEPTH  = 2;
  localparam int OCC_W  = $clog2(2 * DEPTH + 1);
  localparam logic [DATA_W-1:0] NOP = 81'h0_0000_0000_0000_DEAD_BEEF;
`ifdef PIPE_SKID_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 2;
`endif

  logic clk, rst, flush;
  int   n_checks, n_fail;

  pipe_reg_slice_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  pipe_reg_slice #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_VALUE(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs are driven 1 after the rising edge, outputs sampled 1 later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #3;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== NOP) begin n_fail++; $display("FAIL reset_out_data got %0h want %0h", bus.out_data, NOP); end
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick(); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] exp_d;
    logic              exp_v;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.out_ready = 1'b1;
      bus.in_valid  = (c < 3);
      bus.in_data   = DATA_W'(c + 1);
      #1;
      exp_v = (c >= 2 && c <= 4);
      exp_d = exp_v ? DATA_W'(c - 1) : NOP;
      n_checks++; if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL latency_valid cyc %0d got %0b want %0b", c, bus.out_valid, exp_v); end
      n_checks++; if (bus.out_data !== exp_d) begin n_fail++; $display("FAIL latency_data cyc %0d got %0h want %0h", c, bus.out_data, exp_d); end
      if (c < 3) begin
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL latency_in_ready cyc %0d got %0b want 1", c, bus.in_ready); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] vals [4];
    int n_acc, n_out;
    vals[0] = DATA_W'('hA); vals[1] = DATA_W'('hB); vals[2] = DATA_W'('hC); vals[3] = DATA_W'('hD);
    n_acc = 0; n_out = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = (n_acc < 4);
      bus.in_data   = vals[(n_acc < 4) ? n_acc : 0];
      #1;
      if (bus.in_valid && bus.in_ready) n_acc++;
      if (c >= 2) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[0]) begin n_fail++; $display("FAIL stall_hold cyc %0d got v=%0b d=%0h want v=1 d=%0h", c, bus.out_valid, bus.out_data, vals[0]); end
      end
    end
    n_checks++; if (n_acc != CAP) begin n_fail++; $display("FAIL stall_accepts got %0d want %0d", n_acc, CAP); end
    n_checks++; if (bus.occupancy !== OCC_W'(CAP)) begin n_fail++; $display("FAIL stall_occupancy got %0d want %0d", bus.occupancy, CAP); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %0b want 0", bus.in_ready); end
    for (int c = 0; c < 12 && n_out < CAP; c++) begin
      tick();
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        n_checks++; if (bus.out_data !== vals[n_out]) begin n_fail++; $display("FAIL drain_order idx %0d got %0h want %0h", n_out, bus.out_data, vals[n_out]); end
        n_out++;
      end
    end
    n_checks++; if (n_out != CAP) begin n_fail++; $display("FAIL drain_count got %0d want %0d", n_out, CAP); end
    tick(); #1;
    n_checks++; if (bus.occupancy !== OCC_W'(0) || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got occ=%0d v=%0b want occ=0 v=0", bus.occupancy, bus.out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    for (int c = 0; c < 2; c++) begin
      tick();
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_data = (c == 0) ? DATA_W'('h11) : DATA_W'('h22);
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fill_ready cyc %0d got %0b want 1", c, bus.in_ready); end
    end
    tick();
    bus.in_valid = 1'b1; bus.in_data = DATA_W'('h99); flush = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", bus.in_ready); end
    n_checks++; if (bus.occupancy !== OCC_W'(2)) begin n_fail++; $display("FAIL flush_pre_occupancy got %0d want 2", bus.occupancy); end
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== NOP) begin n_fail++; $display("FAIL flush_out_data got %0h want %0h", bus.out_data, NOP); end
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_fail++; $display("FAIL flush_occupancy got %0d want 0", bus.occupancy); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_leak got %0d outputs want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int accepted, seen;
    logic [DATA_W-1:0] last;
    tick();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = DATA_W'('h55);
    #1;
    tick();
    bus.in_valid = 1'b0;
    tick(); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'('h55)) begin n_fail++; $display("FAIL rst_hold got v=%0b d=%0h want v=1 d=55", bus.out_valid, bus.out_data); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== NOP) begin n_fail++; $display("FAIL rst_async_data got %0h want %0h", bus.out_data, NOP); end
    n_checks++; if (bus.occupancy !== OCC_W'(0)) begin n_fail++; $display("FAIL rst_async_occupancy got %0d want 0", bus.occupancy); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_async_in_ready got %0b want 0", bus.in_ready); end
    #1 rst = 1'b0;
    accepted = 0; seen = 0; last = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      bus.out_ready = 1'b1;
      bus.in_valid  = (accepted == 0);
      bus.in_data   = DATA_W'('h66);
      #1;
      if (bus.in_valid && bus.in_ready) accepted = 1;
      if (bus.out_valid) begin seen++; last = bus.out_data; end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (accepted != 1) begin n_fail++; $display("FAIL rst_repush_accept got %0d want 1", accepted); end
    n_checks++; if (seen != 1) begin n_fail++; $display("FAIL rst_repush_count got %0d want 1", seen); end
    n_checks++; if (last !== DATA_W'('h66)) begin n_fail++; $display("FAIL rst_repush_data got %0h want 66", last); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] q[$];
    logic [95:0]       r;
    for (int c = 0; c < 10020; c++) begin
      tick();
      r = {$urandom(), $urandom(), $urandom()};
      bus.in_valid  = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.out_ready = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data   = r[DATA_W-1:0];
      #1;
      n_checks++; if (bus.occupancy !== OCC_W'(q.size())) begin n_fail++; $display("FAIL rand_occupancy cyc %0d got %0d want %0d", c, bus.occupancy, q.size()); end
      if (!bus.out_valid) begin
        n_checks++; if (bus.out_data !== NOP) begin n_fail++; $display("FAIL rand_bubble cyc %0d got %0h want %0h", c, bus.out_data, NOP); end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rand_extra cyc %0d got %0h want none", c, bus.out_data); end
        else begin
          if (bus.out_data !== q[0]) begin n_fail++; $display("FAIL rand_order cyc %0d got %0h want %0h", c, bus.out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d left want 0", q.size()); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_reg_slice.md
PIPE_REG_SLICE -- requirements
Module: pipe_reg_slice

Interface
REQ-001 The block SHALL have parameter DATA_W, default 81, payload width (aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1).
REQ-002 The block SHALL have parameter DEPTH, default 1, number of register stages, legal range 1..4.
REQ-003 The block SHALL have parameter NOP_VALUE, default 0 (DATA_W bits), payload driven for bubbles.
REQ-004 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port: flush  input  1  synchronous pipeline clear.
REQ-007 The block SHALL have port: in_valid  input  1  upstream payload valid.
REQ-008 The block SHALL have port: in_ready  output  1  block accepts payload this cycle.
REQ-009 The block SHALL have port: in_data  input  DATA_W  upstream payload.
REQ-010 The block SHALL have port: out_valid  output  1  downstream payload valid.
REQ-011 The block SHALL have port: out_ready  input  1  downstream accepts (low = stall).
REQ-012 The block SHALL have port: out_data  output  DATA_W  downstream payload.
REQ-013 The block SHALL have port: occupancy  output  clog2(2*DEPTH+1)  entries held.

Function
REQ-014 Transfer SHALL occur on an edge where valid and ready are both high; in_data SHALL be sampled only on accepted edges.
REQ-015 With no backpressure, an accepted payload SHALL appear on out_data with out_valid high exactly DEPTH cycles later; throughput SHALL be 1 per cycle.
REQ-016 Each stage SHALL load from its predecessor when it is empty or its successor takes its entry on the same edge; otherwise it SHALL hold.
REQ-017 A stage that empties without refill SHALL load NOP_VALUE into its data; out_data SHALL equal NOP_VALUE whenever out_valid is low.
REQ-018 Payload order SHALL be preserved; no entry SHALL be dropped or duplicated under any out_ready pattern.
REQ-019 flush SHALL override all transfers: on that edge every valid SHALL clear, every data register SHALL load NOP_VALUE, and occupancy SHALL become 0.
REQ-020 in_ready SHALL be low during a cycle with flush high; out_valid SHALL still reflect pre-edge state, and a downstream take in that cycle SHALL count as consumed.
REQ-021 occupancy SHALL increment on accept-only, decrement on take-only, and stay unchanged on simultaneous accept and take.
REQ-022 out_valid high with out_ready low SHALL hold out_data stable until taken or flushed.

Reset
REQ-023 Asserting rst SHALL immediately, without a clock edge, clear all valid bits, load NOP_VALUE into all data, and drive out_valid 0, out_data NOP_VALUE, occupancy 0, and in_ready 0.
REQ-024 On the first edge after rst deasserts, in_ready SHALL be 1; reset asserted mid-transfer SHALL discard all held entries.

Configuration
REQ-025 With macro PIPE_SKID_EN defined, each stage SHALL add one skid entry (capacity 2 per stage), and in_ready SHALL be a registered function of skid occupancy only (no combinational out_ready-to-in_ready path); max occupancy SHALL be 2*DEPTH.
REQ-026 With PIPE_SKID_EN undefined, each stage SHALL hold one entry, and in_ready SHALL be combinational (stage 0 empty, or stage 0 advancing); max occupancy SHALL be DEPTH.
REQ-027 Latency (REQ-015) and ordering (REQ-018) SHALL be identical in both builds.

Verification
REQ-028 The bench SHALL check: DEPTH=2, out_ready=1; in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 at cycles 2,3,4 with out_valid high.
REQ-029 The bench SHALL check: DEPTH=2, out_ready=0 while pushing 0xA,0xB,0xC,0xD -> without PIPE_SKID_EN in_ready drops after 2 accepts with occupancy 2; with it, after 4 accepts with occupancy 4; releasing out_ready yields 0xA.. in order.
REQ-030 The bench SHALL check: flush asserted with occupancy 2 -> next cycle out_valid 0, out_data NOP_VALUE, occupancy 0, and the flushed entries never appear.
REQ-031 The bench SHALL check: rst pulsed between clock edges while holding 0x55 -> outputs reach reset values before the next edge; after release, pushing 0x66 returns 0x66 only.
REQ-032 The bench SHALL check: random in_valid/out_ready at 50% for 10000 cycles -> output sequence equals the input sequence, occupancy matches the scoreboard, and out_data is NOP_VALUE whenever out_valid is 0.
